// File: rtl/sc_frog_position_register_pkg.sv
// ---------------------------------------------------------------------------
// sc_frog_position_register_pkg
// Definitions shared by the frog position register, the player-control FSM
// and the display mapper.
//   - default playfield geometry and score width
//   - shift-selection codes carried on the 2-bit shift selection bus
//   - position-register FSM state encoding
// ---------------------------------------------------------------------------
package sc_frog_position_register_pkg;

   localparam int ROWS_DEF      = 8;
   localparam int COLS_DEF      = 8;
   localparam int START_COL_DEF = 3;
   localparam int SCORE_W_DEF   = 4;

   // 2'b00 is also treated as hold by the position register.
   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;
   localparam logic [1:0] SHIFT_HOLD  = 2'b11;

   typedef enum logic {
      PLAY = 1'b0,
      GOAL = 1'b1
   } frog_state_t;

endpackage

// File: rtl/sc_frog_position_register_column_shifter.sv
// ---------------------------------------------------------------------------
// sc_frog_column_shifter
// One-hot column register of the frog with saturating left/right shift.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset, loads START_COL
//   load         : re-spawn request, loads START_COL (highest priority)
//   shift_left   : move one column towards the MSB, held at bit COLS-1
//   shift_right  : move one column towards the LSB, held at bit 0
//   col          : one-hot column
// An illegal register value (zero or several bits set) is replaced by the
// spawn column on the next edge, whatever the commands are.
// ---------------------------------------------------------------------------
module sc_frog_column_shifter #(
   parameter int COLS      = 8,
   parameter int START_COL = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            shift_left,
   input  logic            shift_right,
   output logic [COLS-1:0] col
);

   localparam logic [COLS-1:0] START_ONEHOT = COLS'(1) << START_COL;

   logic legal;

   // A value is one-hot when it is non-zero and clearing its lowest set bit
   // leaves nothing behind.
   assign legal = (col != '0) && ((col & (col - COLS'(1))) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= START_ONEHOT;
      end else if (load || !legal) begin
         col <= START_ONEHOT;
      end else if (shift_left && !col[COLS-1]) begin
         col <= col << 1;
      end else if (shift_right && !col[0]) begin
         col <= col >> 1;
      end
   end

endmodule

// File: rtl/sc_frog_position_register.sv
// ---------------------------------------------------------------------------
// sc_frog_position_register
// Frog position responder for the player-control FSM. Keeps the frog's row
// index and one-hot column, flags when the frog sits on the first register,
// detects arrival at the goal row, counts goals and re-spawns the frog.
//   SC_FROGPOS_CLOCK_50           : system clock
//   SC_FROGPOS_RESET_InLow        : asynchronous active-low reset
//   SC_FROGPOS_load0_InLow        : move-down strobe (active-low)
//   SC_FROGPOS_load1_InLow        : move-up strobe (active-low)
//   SC_FROGPOS_shiftselection_In  : 01 left, 10 right, 00/11 hold
//   SC_FROGPOS_clear_InLow        : synchronous re-spawn (active-low)
//   SC_FROGPOS_row_Out            : current row, 0 = bottom
//   SC_FROGPOS_col_Out            : one-hot current column
//   SC_FROGPOS_firstreg_OutLow    : 0 while the frog is on row 0
//   SC_FROGPOS_goal_OutLow        : 0 for the single cycle spent in GOAL
//   SC_FROGPOS_score_Out          : saturating goal counter
//   SC_FROGPOS_state_Out          : current FSM state (observability)
//
// Command handshake: there is no backpressure. Each strobe is a one-cycle
// command that is always accepted at the edge where it is sampled; the
// result is visible on the registered outputs right after that edge. Only
// the highest-priority command of a cycle acts, the rest are dropped.
// ---------------------------------------------------------------------------
module sc_frog_position_register
   import sc_frog_position_register_pkg::*;
#(
   parameter int ROWS      = ROWS_DEF,
   parameter int COLS      = COLS_DEF,
   parameter int START_COL = START_COL_DEF,
   parameter int SCORE_W   = SCORE_W_DEF
) (
   input  logic                    SC_FROGPOS_CLOCK_50,
   input  logic                    SC_FROGPOS_RESET_InLow,
   input  logic                    SC_FROGPOS_load0_InLow,
   input  logic                    SC_FROGPOS_load1_InLow,
   input  logic [1:0]              SC_FROGPOS_shiftselection_In,
   input  logic                    SC_FROGPOS_clear_InLow,
   output logic [$clog2(ROWS)-1:0] SC_FROGPOS_row_Out,
   output logic [COLS-1:0]         SC_FROGPOS_col_Out,
   output logic                    SC_FROGPOS_firstreg_OutLow,
   output logic                    SC_FROGPOS_goal_OutLow,
   output logic [SCORE_W-1:0]      SC_FROGPOS_score_Out,
   output frog_state_t             SC_FROGPOS_state_Out
);

   localparam int                ROW_W    = $clog2(ROWS);
   localparam logic [ROW_W-1:0]  GOAL_ROW = ROW_W'(ROWS - 1);

   frog_state_t state;
   logic        play;
   logic        do_clear;
   logic        no_row_cmd;
   logic        col_load;
   logic        col_left;
   logic        col_right;

   assign play       = (state == PLAY);
   assign do_clear   = play && !SC_FROGPOS_clear_InLow;
   // Shifts act only when no clear, up or down command claims the cycle;
   // an ignored down at row 0 still claims it.
   assign no_row_cmd = SC_FROGPOS_clear_InLow && SC_FROGPOS_load1_InLow &&
                       SC_FROGPOS_load0_InLow;

   // Leaving GOAL re-spawns the column as well as the row.
   assign col_load  = do_clear || !play;
   assign col_left  = play && no_row_cmd &&
                      (SC_FROGPOS_shiftselection_In == SHIFT_LEFT);
   assign col_right = play && no_row_cmd &&
                      (SC_FROGPOS_shiftselection_In == SHIFT_RIGHT);

   sc_frog_column_shifter #(
      .COLS      (COLS),
      .START_COL (START_COL)
   ) u_column (
      .clk         (SC_FROGPOS_CLOCK_50),
      .rst_n       (SC_FROGPOS_RESET_InLow),
      .load        (col_load),
      .shift_left  (col_left),
      .shift_right (col_right),
      .col         (SC_FROGPOS_col_Out)
   );

   always_ff @(posedge SC_FROGPOS_CLOCK_50 or negedge SC_FROGPOS_RESET_InLow) begin
      if (!SC_FROGPOS_RESET_InLow) begin
         state                      <= PLAY;
         SC_FROGPOS_row_Out         <= '0;
         SC_FROGPOS_firstreg_OutLow <= 1'b0;
         SC_FROGPOS_goal_OutLow     <= 1'b1;
         SC_FROGPOS_score_Out       <= '0;
      end else begin
         case (state)
            PLAY: begin
               if (!SC_FROGPOS_clear_InLow) begin
                  SC_FROGPOS_row_Out         <= '0;
                  SC_FROGPOS_firstreg_OutLow <= 1'b0;
               end else if (!SC_FROGPOS_load1_InLow) begin
                  // In PLAY the row never exceeds GOAL_ROW-1, so +1 cannot wrap.
                  SC_FROGPOS_row_Out         <= SC_FROGPOS_row_Out + ROW_W'(1);
                  SC_FROGPOS_firstreg_OutLow <= 1'b1;
                  if (SC_FROGPOS_row_Out + ROW_W'(1) == GOAL_ROW) begin
                     state                  <= GOAL;
                     SC_FROGPOS_goal_OutLow <= 1'b0;
                     if (SC_FROGPOS_score_Out != {SCORE_W{1'b1}}) begin
                        SC_FROGPOS_score_Out <= SC_FROGPOS_score_Out + SCORE_W'(1);
                     end
                  end
               end else if (!SC_FROGPOS_load0_InLow) begin
                  if (SC_FROGPOS_row_Out != '0) begin
                     SC_FROGPOS_row_Out <= SC_FROGPOS_row_Out - ROW_W'(1);
                  end
                  // Row 1 steps onto the first register; row 0 stays there.
                  SC_FROGPOS_firstreg_OutLow <= (SC_FROGPOS_row_Out > ROW_W'(1));
               end
            end
            GOAL: begin
               // One-cycle display of the goal row, all commands ignored.
               state                      <= PLAY;
               SC_FROGPOS_row_Out         <= '0;
               SC_FROGPOS_firstreg_OutLow <= 1'b0;
               SC_FROGPOS_goal_OutLow     <= 1'b1;
            end
            default: begin
               state <= PLAY;
            end
         endcase
      end
   end

   assign SC_FROGPOS_state_Out = state;

endmodule

// File: tb/tb_sc_frog_position_register.sv
// ---------------------------------------------------------------------------
// tb_sc_frog_position_register
// Scoreboard bench: the driver applies one command per cycle, advances a
// behavioural model of the frog and pushes the expected output vector; a
// monitor pops and compares after every rising edge.
// Vector layout: {goal_state, row[2:0], col[7:0], firstreg_n, goal_n, score[3:0]}
// ---------------------------------------------------------------------------
module tb_sc_frog_position_register;
   import sc_frog_position_register_pkg::*;

   localparam int ROWS      = 8;
   localparam int COLS      = 8;
   localparam int START_COL = 3;
   localparam int SCORE_W   = 4;
   localparam int EXP_W     = 18;

   logic              clk;
   logic              rst_n;
   logic              load0_n;
   logic              load1_n;
   logic [1:0]        shift_sel;
   logic              clear_n;
   logic [2:0]        row;
   logic [COLS-1:0]   col;
   logic              firstreg_n;
   logic              goal_n;
   logic [SCORE_W-1:0] score;
   frog_state_t       state;

   logic [EXP_W-1:0]  exp_q[$];
   int                checks;
   int                errors;

   // behavioural model: plain integers
   int                m_row;
   int                m_col;
   int                m_score;
   bit                m_goal;

   sc_frog_position_register #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .START_COL (START_COL),
      .SCORE_W   (SCORE_W)
   ) dut (
      .SC_FROGPOS_CLOCK_50          (clk),
      .SC_FROGPOS_RESET_InLow       (rst_n),
      .SC_FROGPOS_load0_InLow       (load0_n),
      .SC_FROGPOS_load1_InLow       (load1_n),
      .SC_FROGPOS_shiftselection_In (shift_sel),
      .SC_FROGPOS_clear_InLow       (clear_n),
      .SC_FROGPOS_row_Out           (row),
      .SC_FROGPOS_col_Out           (col),
      .SC_FROGPOS_firstreg_OutLow   (firstreg_n),
      .SC_FROGPOS_goal_OutLow       (goal_n),
      .SC_FROGPOS_score_Out         (score),
      .SC_FROGPOS_state_Out         (state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [EXP_W-1:0] actual_vec();
      return {(state == GOAL), row, col, firstreg_n, goal_n, score};
   endfunction

   function automatic logic [EXP_W-1:0] model_vec();
      logic [COLS-1:0] oh;
      oh = '0;
      oh[m_col] = 1'b1;
      return {m_goal, 3'(m_row), oh, (m_row != 0), !m_goal, 4'(m_score)};
   endfunction

   task automatic check_vec(input string name, input logic [EXP_W-1:0] act,
                            input logic [EXP_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual st=%0b row=%0d col=%b fr=%0b gl=%0b sc=%0d required st=%0b row=%0d col=%b fr=%0b gl=%0b sc=%0d",
                  name, $time, act[17], act[16:14], act[13:6], act[5], act[4], act[3:0],
                  exp[17], exp[16:14], exp[13:6], exp[5], exp[4], exp[3:0]);
      end
   endtask

   task automatic model_reset();
      m_row   = 0;
      m_col   = START_COL;
      m_score = 0;
      m_goal  = 1'b0;
   endtask

   // One cycle of the frog's rules.
   task automatic model_step(input bit c_n, input bit up_n, input bit dn_n,
                             input logic [1:0] sel);
      if (m_goal) begin
         m_goal = 1'b0;
         m_row  = 0;
         m_col  = START_COL;
      end else if (!c_n) begin
         m_row = 0;
         m_col = START_COL;
      end else if (!up_n) begin
         m_row = m_row + 1;
         if (m_row == ROWS - 1) begin
            m_goal  = 1'b1;
            m_score = (m_score < (1 << SCORE_W) - 1) ? m_score + 1 : m_score;
         end
      end else if (!dn_n) begin
         if (m_row > 0) m_row = m_row - 1;
      end else if (sel == 2'b01) begin
         if (m_col < COLS - 1) m_col = m_col + 1;
      end else if (sel == 2'b10) begin
         if (m_col > 0) m_col = m_col - 1;
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit c_n, input bit up_n, input bit dn_n,
                        input logic [1:0] sel);
      @(negedge clk);
      clear_n   = c_n;
      load1_n   = up_n;
      load0_n   = dn_n;
      shift_sel = sel;
      model_step(c_n, up_n, dn_n, sel);
      exp_q.push_back(model_vec());
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b1, 2'b00);
   endtask

   task automatic drive_random(input int n);
      for (int i = 0; i < n; i++) begin
         drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         check_vec("scoreboard", actual_vec(), exp_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   logic [EXP_W-1:0] reset_vec;

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      clear_n   = 1'b1;
      load1_n   = 1'b1;
      load0_n   = 1'b1;
      shift_sel = 2'b00;
      model_reset();
      reset_vec = {1'b0, 3'd0, 8'b0000_1000, 1'b0, 1'b1, 4'd0};

      repeat (3) @(posedge clk);
      #2;
      check_vec("reset_held", actual_vec(), reset_vec);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_vec("reset_release", actual_vec(), reset_vec);

      // up, down, down at row 0
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b1, 1'b0, 2'b00);
      drive(1'b1, 1'b1, 1'b0, 2'b00);

      // column saturation
      repeat (5) drive(1'b1, 1'b1, 1'b1, 2'b01);
      repeat (8) drive(1'b1, 1'b1, 1'b1, 2'b10);
      drive(1'b1, 1'b1, 1'b1, 2'b11);

      // goal; up strobe during GOAL is ignored
      drive(1'b0, 1'b1, 1'b1, 2'b00);
      repeat (7) drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b01);
      idle();

      // priority at row 2, then clear
      repeat (2) drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 2'b01);
      drive(1'b1, 1'b1, 1'b1, 2'b01);
      drive(1'b0, 1'b0, 1'b0, 2'b01);
      idle();

      // randomized traffic
      drive_random(400);

      // drive the score into saturation
      for (int g = 0; g < 16; g++) begin
         idle();
         drive(1'b0, 1'b1, 1'b1, 2'b00);
         repeat (7) drive(1'b1, 1'b0, 1'b1, 2'b00);
         idle();
      end
      #2;
      checks++;
      if (score !== 4'd15) begin
         errors++;
         $display("FAIL score_saturated actual %0d required 15", score);
      end

      // one more goal, then reset in the middle of the GOAL cycle
      idle();
      drive(1'b0, 1'b1, 1'b1, 2'b00);
      repeat (7) drive(1'b1, 1'b0, 1'b1, 2'b00);
      @(posedge clk);
      #2;
      checks++;
      if (goal_n !== 1'b0) begin
         errors++;
         $display("FAIL goal_before_reset actual goal_n=%0b required 0", goal_n);
      end
      rst_n = 1'b0;
      clear_n = 1'b1;
      load1_n = 1'b1;
      load0_n = 1'b1;
      shift_sel = 2'b00;
      #1;
      check_vec("async_reset_mid_goal", actual_vec(), reset_vec);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      drive_random(60);
      idle();

      // bounded drain of the scoreboard
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual %0d pending required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
